// File: rtl/asic_iosequencer.sv
// ----------------------------------------------------------------------------
// asic_iosequencer
//
// Power-up and hold sequencer for the sky130 GPIO ring. One tech_cfg bus is
// broadcast to every asic_iobuf. Once supplies are good, the sequencer steps
// the high-voltage enables in a fixed order. It then releases the pad hold
// (HLD_H_N) and applies the drive mode. A level hold_req/hold_ack handshake
// lets the SoC freeze the pads. Losing pwr_good forces all pads to the safe,
// all-zero configuration.
//
// Handshake: hold_req is a level. hold_ack rises in the same registered
// update in which HLD_H_N drops and ready falls. hold_ack stays high as long
// as the pads are held. hold_ack falls on the first edge after hold_req is
// released. ready returns one full stage later, unless hold_req comes back
// first.
//
// Optional build macro: ASIC_IOSEQ_STEPCFG_EN
//   When defined, this adds the input step_cfg[CNT_W-1:0]. Its value, sampled
//   on entry to PWR_WAIT (0 treated as 1), is the stage length. Without the
//   macro the stage length is STEP_CYCLES.
//
// Ports
//   clk, rst    sequencer clock, async active-high reset
//   pwr_good    supply-good, already synchronous to clk
//   cfg_static  tech_cfg[12:6], captured only while OFF
//   cfg_vdda    tech_cfg[4:3], captured on entry to EN_IO
//   cfg_dm      tech_cfg[15:13] drive mode, live in ACTIVE
//   hold_req    level request to freeze pads
//   tech_cfg    pad control bus (registered)
//   hold_ack    pads currently held (registered)
//   ready       pads fully enabled and not held (registered)
//   state_o     current state encoding, for debug
// ----------------------------------------------------------------------------
module asic_iosequencer #(
  parameter int TECH_CFG_WIDTH = 16,
  parameter int STEP_CYCLES    = 16,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pwr_good,
  input  logic [6:0]                cfg_static,
  input  logic [1:0]                cfg_vdda,
  input  logic [2:0]                cfg_dm,
  input  logic                      hold_req,
`ifdef ASIC_IOSEQ_STEPCFG_EN
  input  logic [CNT_W-1:0]          step_cfg,
`endif
  output logic [TECH_CFG_WIDTH-1:0] tech_cfg,
  output logic                      hold_ack,
  output logic                      ready,
  output logic [2:0]                state_o
);

  generate
    if (TECH_CFG_WIDTH != 16) begin : g_bad_width
      $error("asic_iosequencer: TECH_CFG_WIDTH must be 16");
    end
    if (STEP_CYCLES < 1 || STEP_CYCLES > 65535) begin : g_bad_step
      $error("asic_iosequencer: STEP_CYCLES must be within 1..65535");
    end
    if (CNT_W < 1 || (CNT_W < 31 && (2 ** CNT_W) <= STEP_CYCLES)) begin : g_bad_cnt
      $error("asic_iosequencer: CNT_W too narrow for STEP_CYCLES");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_EN_H     = 3'd2,
    S_EN_IO    = 3'd3,
    S_ACTIVE   = 3'd4,
    S_HOLD     = 3'd5,
    S_UNHOLD   = 3'd6
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            step_last;
  logic                        cnt_done;
  logic [6:0]                  shadow_q, shadow_d;
  logic [1:0]                  vdda_q, vdda_d;
  logic [2:0]                  dm_q, dm_d;
  logic [TECH_CFG_WIDTH-1:0]   cfg_q, cfg_d;
  logic                        hold_ack_q, hold_ack_d;
  logic                        ready_q, ready_d;

  // Last counter value of a timed stage: stage length minus one.
`ifdef ASIC_IOSEQ_STEPCFG_EN
  logic [CNT_W-1:0] step_len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_len_q <= CNT_W'(STEP_CYCLES);
    end else if (state_q == S_OFF && pwr_good) begin
      step_len_q <= (step_cfg == '0) ? CNT_W'(1) : step_cfg;
    end
  end

  assign step_last = step_len_q - CNT_W'(1);
`else
  assign step_last = CNT_W'(STEP_CYCLES - 1);
`endif

  assign cnt_done = (cnt_q == step_last);

  // Next state and step counter. Supply loss beats everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (state_q != S_OFF && !pwr_good) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF:      if (pwr_good) state_d = S_PWR_WAIT;
        S_PWR_WAIT: if (cnt_done) state_d = S_EN_H;   else cnt_d = cnt_q + CNT_W'(1);
        S_EN_H:     if (cnt_done) state_d = S_EN_IO;  else cnt_d = cnt_q + CNT_W'(1);
        S_EN_IO:    if (cnt_done) state_d = S_ACTIVE; else cnt_d = cnt_q + CNT_W'(1);
        S_ACTIVE:   if (hold_req) state_d = S_HOLD;
        S_HOLD:     if (!hold_req) state_d = S_UNHOLD;
        S_UNHOLD: begin
          // A fresh request during the release window re-holds at once
          // and discards the partial count.
          if (hold_req)      state_d = S_HOLD;
          else if (cnt_done) state_d = S_ACTIVE;
          else               cnt_d   = cnt_q + CNT_W'(1);
        end
        default:    state_d = S_OFF;
      endcase
    end
  end

  // The registered outputs are derived from the state being entered, so
  // they change on the same edge as the state.
  always_comb begin
    shadow_d   = (state_q == S_OFF) ? cfg_static : shadow_q;
    vdda_d     = (state_d == S_EN_IO && state_q != S_EN_IO) ? cfg_vdda : vdda_q;
    // DM tracks cfg_dm only while ACTIVE. It keeps its last value through
    // HOLD and UNHOLD.
    dm_d       = (state_d == S_ACTIVE) ? cfg_dm : dm_q;
    hold_ack_d = (state_d == S_HOLD);
    ready_d    = (state_d == S_ACTIVE);

    cfg_d = '0;
    case (state_d)
      S_EN_H: begin
        cfg_d[2:1] = 2'b11;
      end
      S_EN_IO, S_ACTIVE, S_HOLD, S_UNHOLD: begin
        cfg_d[2:1]  = 2'b11;
        cfg_d[5]    = 1'b1;
        cfg_d[4:3]  = vdda_d;
        cfg_d[12:6] = shadow_q;
      end
      default: ;
    endcase
    if (state_d == S_ACTIVE) begin
      cfg_d[0] = 1'b1;
    end
    if (state_d == S_ACTIVE || state_d == S_HOLD || state_d == S_UNHOLD) begin
      cfg_d[15:13] = dm_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      shadow_q   <= '0;
      vdda_q     <= '0;
      dm_q       <= '0;
      cfg_q      <= '0;
      hold_ack_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      vdda_q     <= vdda_d;
      dm_q       <= dm_d;
      cfg_q      <= cfg_d;
      hold_ack_q <= hold_ack_d;
      ready_q    <= ready_d;
    end
  end

  assign tech_cfg = cfg_q;
  assign hold_ack = hold_ack_q;
  assign ready    = ready_q;
  assign state_o  = state_q;

endmodule
